// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with power-of-two depth, programmable almost-full/almost-empty thresholds and a live fill level.
// Define SYNC_FIFO_ERR_FLAGS_EN to build the sticky overflow/underflow detectors; otherwise those ports are tied low.
module sync_fifo_param #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 3,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              r_en,
    output logic [DATA_W-1:0] rdata,
    output logic              rvalid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] FULL_LVL   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AFULL_LVL  = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AEMPTY_LVL = (ADDR_W + 1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W:0]   wptr;
    logic [ADDR_W:0]   rptr;
    logic              wr_acc;
    logic              rd_acc;

    // Flags decode the level register directly, so they move in the same cycle as level.
    assign full         = (level == FULL_LVL);
    assign empty        = (level == '0);
    assign almost_full  = (level >= AFULL_LVL);
    assign almost_empty = (level <= AEMPTY_LVL);

    assign wr_acc = w_en & ~full;
    assign rd_acc = r_en & ~empty;

    // NOTE: the storage array has no reset; stale words are unreachable because the pointers restart at zero.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wptr[ADDR_W-1:0]] <= wdata;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            rptr   <= '0;
            level  <= '0;
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_acc;
            if (wr_acc) begin
                wptr <= wptr + 1'b1;
            end
            if (rd_acc) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr[ADDR_W-1:0]];
            end
            case ({wr_acc, rd_acc})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    // Sticky until reset; a rejected request is flagged one cycle after it is seen.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (w_en && full) begin
                overflow_q <= 1'b1;
            end
            if (r_en && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param: a queue scoreboard predicts every read word, plus a level/flag model checked each cycle.
module tb_sync_fifo_param;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        w_en = 1'b0;
    logic [31:0] wdata = '0;
    logic        r_en = 1'b0;
    logic [31:0] rdata;
    logic        rvalid;
    logic        full;
    logic        empty;
    logic        almost_full;
    logic        almost_empty;
    logic [3:0]  level;
    logic        overflow;
    logic        underflow;

    int total = 0;
    int bad   = 0;

    // Bench-side model of the FIFO.
    logic [31:0] sb[$];
    int          m_level = 0;
    logic [31:0] m_rdata = '0;
    bit          m_ovf   = 1'b0;
    bit          m_unf   = 1'b0;

    sync_fifo_param #(
        .DATA_W(32), .ADDR_W(3), .AFULL_TH(6), .AEMPTY_TH(1)
    ) dut (
        .clk(clk), .rst(rst), .w_en(w_en), .wdata(wdata), .r_en(r_en),
        .rdata(rdata), .rvalid(rvalid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .level(level),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock with the currently driven inputs, update the model, then compare outputs.
    task automatic tick();
        bit          wacc;
        bit          racc;
        logic [31:0] exp_d;
        wacc  = w_en && !rst && (m_level != 8);
        racc  = r_en && !rst && (m_level != 0);
        exp_d = '0;
        if (!rst) begin
            if (w_en && m_level == 8) m_ovf = ERR_EN;
            if (r_en && m_level == 0) m_unf = ERR_EN;
        end
        if (racc) begin
            if (sb.size() == 0) begin
                chk("scoreboard_empty", 32'd1, 32'd0);
            end else begin
                exp_d = sb.pop_front();
            end
        end
        if (wacc) sb.push_back(wdata);
        @(posedge clk);
        #1;
        if (rst) begin
            sb.delete();
            m_level = 0;
            m_rdata = '0;
            m_ovf   = 1'b0;
            m_unf   = 1'b0;
            racc    = 1'b0;
        end else begin
            m_level = m_level + int'(wacc) - int'(racc);
            if (racc) m_rdata = exp_d;
        end
        chk("rvalid", 32'(rvalid), 32'(racc));
        chk("rdata", rdata, m_rdata);
        chk("level", 32'(level), 32'(m_level));
        chk("full", 32'(full), 32'(m_level == 8));
        chk("empty", 32'(empty), 32'(m_level == 0));
        chk("almost_full", 32'(almost_full), 32'(m_level >= 6));
        chk("almost_empty", 32'(almost_empty), 32'(m_level <= 1));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    initial begin
        // Reset and idle.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("idle_level", 32'(level), 32'd0);
        chk("idle_rdata", rdata, 32'd0);

        // Fill to full, then one dropped write.
        w_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wdata = 32'hA0 + 32'(i);
            tick();
            if (i == 0) chk("ae_after_w1", 32'(almost_empty), 32'd1);
            if (i == 1) chk("ae_after_w2", 32'(almost_empty), 32'd0);
            if (i == 4) chk("af_after_w5", 32'(almost_full), 32'd0);
            if (i == 5) chk("af_after_w6", 32'(almost_full), 32'd1);
        end
        chk("full_after_w8", 32'(full), 32'd1);
        chk("level_after_w8", 32'(level), 32'd8);
        wdata = 32'hFF;
        tick();
        chk("overflow_after_w9", 32'(overflow), 32'(ERR_EN));
        chk("level_after_w9", 32'(level), 32'd8);
        w_en = 1'b0;

        // Drain: eight words out in order, ninth read rejected.
        r_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("drain_word", rdata, 32'hA0 + 32'(i));
        end
        tick();
        chk("drain9_rvalid", 32'(rvalid), 32'd0);
        chk("drain9_rdata", rdata, 32'hA7);
        chk("drain9_empty", 32'(empty), 32'd1);
        chk("underflow_after_r9", 32'(underflow), 32'(ERR_EN));
        r_en = 1'b0;

        // Simultaneous read and write holding level 4 across pointer wraps.
        w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wdata = 32'h100 + 32'(i);
            tick();
        end
        r_en = 1'b1;
        for (int i = 4; i < 24; i++) begin
            wdata = 32'h100 + 32'(i);
            tick();
            chk("steady_level", 32'(level), 32'd4);
        end
        w_en = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        r_en = 1'b0;

        // Boundary: read and write together while empty.
        chk("pre_empty", 32'(empty), 32'd1);
        w_en  = 1'b1;
        r_en  = 1'b1;
        wdata = 32'h200;
        tick();
        chk("empty_rw_level", 32'(level), 32'd1);
        chk("empty_rw_rvalid", 32'(rvalid), 32'd0);
        r_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            wdata = 32'h200 + 32'(i);
            tick();
        end
        // Boundary: read and write together while full; the write word is lost.
        r_en  = 1'b1;
        wdata = 32'hDEAD;
        tick();
        chk("full_rw_level", 32'(level), 32'd7);
        chk("full_rw_rdata", rdata, 32'h200);
        w_en = 1'b0;
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("full_rw_order", rdata, 32'h200 + 32'(i));
        end
        r_en = 1'b0;
        tick();

        // Mid-stream reset at level 5 with a write pending.
        w_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wdata = 32'h300 + 32'(i);
            tick();
        end
        chk("pre_reset_level", 32'(level), 32'd5);
        rst   = 1'b1;
        wdata = 32'h3FF;
        tick();
        chk("reset_level", 32'(level), 32'd0);
        chk("reset_empty", 32'(empty), 32'd1);
        rst   = 1'b0;
        wdata = 32'h55;
        tick();
        w_en = 1'b0;
        r_en = 1'b1;
        tick();
        chk("post_reset_read", rdata, 32'h55);
        r_en = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
